frame_update_ctrl: RTL and testbench
====================================

FRAME_UPDATE_CTRL -- requirements
Module: frame_update_ctrl

Interface
REQ-001 Parameters: H_ACTIVE, default 800, active pixels per line; V_ACTIVE, default 600, active lines per frame; TIMEOUT_CYC, default 4096, maximum cycles to wait for upd_done.
REQ-002 pixel_clk  in  1  sole clock; all logic rising-edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 h_coord  in  11  horizontal pixel coordinate from display controller.
REQ-005 v_coord  in  10  vertical pixel coordinate from display controller.
REQ-006 accel_data_x / accel_data_y  in  8 each  live accelerometer samples, quasi-static.
REQ-007 button_c_d  in  1  debounced centre-button press pulse, one cycle.
REQ-008 upd_done  in  1  one-cycle pulse from scene logic: frame update finished.
REQ-009 clr_err  in  1  one-cycle pulse: clear sticky error flags.
REQ-010 upd_start  out  1  one-cycle pulse: scene logic may begin frame update.
REQ-011 accel_x_end_of_frame / accel_y_end_of_frame  out  8 each  accelerometer values committed for the current frame.
REQ-012 regime_status  out  2  committed display regime, values 0..2.
REQ-013 frame_cnt  out  16  count of committed frames.
REQ-014 timeout_err / overrun_err  out  1 each  sticky error flags.

Function
REQ-015 frame_end SHALL be a one-cycle internal pulse, asserted when v_coord == V_ACTIVE and h_coord == 0. The pulse is registered, so frame_end lags the coordinate match by 1 cycle.
REQ-016 FSM states: IDLE, SAMPLE, REQ, WAIT, COMMIT.
REQ-017 IDLE: on frame_end -> SAMPLE; otherwise remain in IDLE.
REQ-018 SAMPLE: capture accel_data_x/y into shadow registers; -> REQ next cycle.
REQ-019 REQ: assert upd_start for exactly this cycle; clear the timeout counter; -> WAIT.
REQ-020 WAIT: increment the timeout counter each cycle.
  - upd_done -> COMMIT.
  - Counter reaching TIMEOUT_CYC-1 without upd_done -> COMMIT and set timeout_err.
  - upd_done in the same cycle as expiry: done wins; timeout_err is not set.
REQ-021 COMMIT (one cycle):
  - copy shadows to accel_*_end_of_frame;
  - apply the pending regime to regime_status;
  - increment frame_cnt, wrapping 16'hFFFF -> 0;
  - -> IDLE.
REQ-022 Latency: upd_start SHALL occur exactly 2 cycles after frame_end. Outputs SHALL update on the cycle after upd_done is accepted.
REQ-023 upd_done outside WAIT SHALL be ignored.
REQ-024 frame_end in any state other than IDLE SHALL set overrun_err. That frame SHALL be skipped; the sequence in progress continues unaffected.
REQ-025 button_c_d SHALL advance pending_regime 0->1->2->0 in any state.
  - Multiple presses within one frame accumulate.
  - regime_status changes only in COMMIT.
REQ-026 clr_err SHALL clear both error flags. If clr_err coincides with a set event, set wins.
REQ-027 Committed outputs SHALL remain stable between COMMIT cycles.

Reset
REQ-028 Asserting rst_n low SHALL force the following immediately, including mid-sequence:
  - state = IDLE;
  - upd_start = 0;
  - accel_*_end_of_frame = 0;
  - regime_status = 0, pending_regime = 0;
  - frame_cnt = 0;
  - both error flags = 0;
  - shadows and timeout counter = 0.
REQ-029 After rst_n deasserts, the first action SHALL be waiting for the next frame_end. A partially elapsed frame SHALL NOT start a sequence.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, the regime enum (REGIME_0..REGIME_2), and default constants for H_ACTIVE, V_ACTIVE and TIMEOUT_CYC.
REQ-031 One sub-module, frame_edge_det, SHALL produce the registered frame_end pulse from the coordinates. All other logic is flat in frame_update_ctrl.

Verification
REQ-032 Nominal: accel x=8'h12, y=8'hF0; frame_end; upd_done 5 cycles after upd_start -> upd_start 2 cycles after frame_end; outputs 12/F0 and frame_cnt=1 the cycle after upd_done.
REQ-033 Timeout: TIMEOUT_CYC=16, no upd_done -> COMMIT after 16 WAIT cycles; timeout_err=1; frame_cnt increments; clr_err clears the flag.
REQ-034 Done/expiry collision: upd_done on the expiry cycle -> timeout_err stays 0.
REQ-035 Overrun: a second frame_end while in WAIT -> overrun_err=1; exactly one upd_start per accepted frame; frame_cnt +1 only.
REQ-036 Regime: three button_c_d pulses during WAIT with regime_status=0 -> regime_status stays 0 until COMMIT, then 0 (wrap). Two pulses -> 2 at COMMIT.
REQ-037 Reset mid-WAIT, with frame_cnt=16'hFFFF pre-loaded by 65535 frames (or forced) -> all outputs 0, state IDLE; the next frame_end produces a normal sequence. Separately, the 16'hFFFF -> 0 wrap is checked without reset.

Source files
------------

// File: rtl/frame_update_ctrl_pkg.sv
// frame_update_ctrl_pkg
// Shared types and defaults for the frame update controller:
//   fsm_state_e  - controller sequencing states
//   regime_e     - display regime selected by the centre button
//   DEF_*        - default timing parameters
//   next_regime  - cyclic regime advance 0 -> 1 -> 2 -> 0
package frame_update_ctrl_pkg;

  localparam int unsigned DEF_H_ACTIVE    = 800;
  localparam int unsigned DEF_V_ACTIVE    = 600;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_REQ,
    ST_WAIT,
    ST_COMMIT
  } fsm_state_e;

  typedef enum logic [1:0] {
    REGIME_0 = 2'd0,
    REGIME_1 = 2'd1,
    REGIME_2 = 2'd2
  } regime_e;

  function automatic regime_e next_regime(input regime_e r);
    case (r)
      REGIME_0: return REGIME_1;
      REGIME_1: return REGIME_2;
      default:  return REGIME_0;
    endcase
  endfunction

endpackage

// File: rtl/frame_update_ctrl_if.sv
// frame_update_ctrl_if
// Handshake and committed-state bundle between the frame update controller
// and the scene logic.
//   upd_start            controller -> scene : begin frame update (pulse)
//   upd_done             scene -> controller : frame update finished (pulse)
//   clr_err              scene -> controller : clear sticky errors (pulse)
//   accel_*_end_of_frame controller -> scene : committed accelerometer values
//   regime_status        controller -> scene : committed display regime
//   frame_cnt            controller -> scene : committed frame count
//   timeout_err/overrun_err controller -> scene : sticky error flags
// Modports: master = controller side, slave = scene logic side.
interface frame_update_ctrl_if;
  import frame_update_ctrl_pkg::*;

  logic        upd_start;
  logic        upd_done;
  logic        clr_err;
  logic [7:0]  accel_x_end_of_frame;
  logic [7:0]  accel_y_end_of_frame;
  regime_e     regime_status;
  logic [15:0] frame_cnt;
  logic        timeout_err;
  logic        overrun_err;

  modport master (
    output upd_start,
    output accel_x_end_of_frame,
    output accel_y_end_of_frame,
    output regime_status,
    output frame_cnt,
    output timeout_err,
    output overrun_err,
    input  upd_done,
    input  clr_err
  );

  modport slave (
    input  upd_start,
    input  accel_x_end_of_frame,
    input  accel_y_end_of_frame,
    input  regime_status,
    input  frame_cnt,
    input  timeout_err,
    input  overrun_err,
    output upd_done,
    output clr_err
  );

endinterface

// File: rtl/frame_update_ctrl_frame_edge_det.sv
// frame_edge_det
// Produces a registered one-cycle frame_end pulse when the display scan
// reaches the first pixel after the active area (v == V_ACTIVE, h == 0).
// Ports:
//   pixel_clk, rst_n  clock and asynchronous active-low reset
//   h_coord, v_coord  current scan coordinates
//   frame_end         registered pulse, one cycle after the coordinate match
module frame_edge_det #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [10:0] h_coord,
  input  logic [9:0]  v_coord,
  output logic        frame_end
);

  // Active area must fit in the coordinate buses.
  if (H_ACTIVE > 2047 || V_ACTIVE > 1023) begin : g_bad_params
    $error("frame_edge_det: active area exceeds coordinate width");
  end

  logic frame_end_d;
  logic frame_end_q;

  always_comb begin
    frame_end_d = (v_coord == 10'(V_ACTIVE)) && (h_coord == '0);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= frame_end_d;
    end
  end

  assign frame_end = frame_end_q;

endmodule

// File: rtl/frame_update_ctrl.sv
// frame_update_ctrl
// Per-frame update sequencer: at each frame end it samples the accelerometer,
// requests a scene update, waits (bounded) for completion, then commits the
// sampled values, pending regime and frame count in one step.
// Ports:
//   pixel_clk, rst_n            clock and asynchronous active-low reset
//   h_coord, v_coord            display scan coordinates
//   accel_data_x/accel_data_y   live accelerometer samples
//   button_c_d                  debounced centre-button pulse (regime advance)
//   bus (master)                upd_start/upd_done handshake, clr_err,
//                               committed outputs and sticky error flags
module frame_update_ctrl
  import frame_update_ctrl_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 pixel_clk,
  input  logic                 rst_n,
  input  logic [10:0]          h_coord,
  input  logic [9:0]           v_coord,
  input  logic [7:0]           accel_data_x,
  input  logic [7:0]           accel_data_y,
  input  logic                 button_c_d,
  frame_update_ctrl_if.master  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

  logic frame_end;

  frame_edge_det #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_edge_det (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .h_coord   (h_coord),
    .v_coord   (v_coord),
    .frame_end (frame_end)
  );

  fsm_state_e  state_q,       state_d;
  logic [7:0]  shadow_x_q,    shadow_x_d;
  logic [7:0]  shadow_y_q,    shadow_y_d;
  logic [TW-1:0] tmo_cnt_q,   tmo_cnt_d;
  logic        upd_start_q,   upd_start_d;
  logic [7:0]  accel_x_q,     accel_x_d;
  logic [7:0]  accel_y_q,     accel_y_d;
  regime_e     regime_q,      regime_d;
  regime_e     pending_q,     pending_d;
  logic [15:0] frame_cnt_q,   frame_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        overrun_err_q, overrun_err_d;

  logic expire;
  logic accept;
  logic timeout_set;
  logic overrun_set;

  always_comb begin
    state_d       = state_q;
    shadow_x_d    = shadow_x_q;
    shadow_y_d    = shadow_y_q;
    tmo_cnt_d     = tmo_cnt_q;
    upd_start_d   = 1'b0;
    accel_x_d     = accel_x_q;
    accel_y_d     = accel_y_q;
    regime_d      = regime_q;
    pending_d     = pending_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_set   = 1'b0;

    expire      = (state_q == ST_WAIT) && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
    accept      = (state_q == ST_WAIT) && (bus.upd_done || expire);
    overrun_set = frame_end && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (frame_end) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        shadow_x_d  = accel_data_x;
        shadow_y_d  = accel_data_y;
        // upd_start is registered, so it is raised on entry to REQ.
        upd_start_d = 1'b1;
        state_d     = ST_REQ;
      end
      ST_REQ: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (accept) begin
          // Committed registers load on the edge entering COMMIT so they are
          // visible the cycle after upd_done is accepted.
          accel_x_d   = shadow_x_q;
          accel_y_d   = shadow_y_q;
          regime_d    = pending_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          timeout_set = !bus.upd_done;
          state_d     = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (button_c_d) pending_d = next_regime(pending_q);

    // Set has priority over clear.
    timeout_err_d = timeout_set ? 1'b1 : (bus.clr_err ? 1'b0 : timeout_err_q);
    overrun_err_d = overrun_set ? 1'b1 : (bus.clr_err ? 1'b0 : overrun_err_q);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shadow_x_q    <= '0;
      shadow_y_q    <= '0;
      tmo_cnt_q     <= '0;
      upd_start_q   <= 1'b0;
      accel_x_q     <= '0;
      accel_y_q     <= '0;
      regime_q      <= REGIME_0;
      pending_q     <= REGIME_0;
      frame_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_x_q    <= shadow_x_d;
      shadow_y_q    <= shadow_y_d;
      tmo_cnt_q     <= tmo_cnt_d;
      upd_start_q   <= upd_start_d;
      accel_x_q     <= accel_x_d;
      accel_y_q     <= accel_y_d;
      regime_q      <= regime_d;
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign bus.upd_start            = upd_start_q;
  assign bus.accel_x_end_of_frame = accel_x_q;
  assign bus.accel_y_end_of_frame = accel_y_q;
  assign bus.regime_status        = regime_q;
  assign bus.frame_cnt            = frame_cnt_q;
  assign bus.timeout_err          = timeout_err_q;
  assign bus.overrun_err          = overrun_err_q;

endmodule

// File: tb/tb_frame_update_ctrl.sv
module tb_frame_update_ctrl;

  localparam int unsigned V_A = 4;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic [7:0]  accel_data_x;
  logic [7:0]  accel_data_y;
  logic        button_c_d;

  int n_tests = 0;
  int n_fail  = 0;

  frame_update_ctrl_if bus_if ();

  frame_update_ctrl #(
    .H_ACTIVE    (8),
    .V_ACTIVE    (V_A),
    .TIMEOUT_CYC (16)
  ) dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .h_coord      (h_coord),
    .v_coord      (v_coord),
    .accel_data_x (accel_data_x),
    .accel_data_y (accel_data_y),
    .button_c_d   (button_c_d),
    .bus          (bus_if)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(negedge pixel_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_start"}, 32'(bus_if.upd_start), 0);
    check({p, "_ax"},    32'(bus_if.accel_x_end_of_frame), 0);
    check({p, "_ay"},    32'(bus_if.accel_y_end_of_frame), 0);
    check({p, "_reg"},   32'(bus_if.regime_status), 0);
    check({p, "_cnt"},   32'(bus_if.frame_cnt), 0);
    check({p, "_terr"},  32'(bus_if.timeout_err), 0);
    check({p, "_oerr"},  32'(bus_if.overrun_err), 0);
  endtask

  // Drive one coordinate match; returns one negedge later.
  task automatic frame_pulse();
    v_coord = 10'(V_A);
    h_coord = '0;
    tick();
    v_coord = '0;
    h_coord = 11'd3;
  endtask

  // Frame end, then upd_start expected exactly 2 cycles after frame_end.
  task automatic run_start(input string p);
    frame_pulse();
    tick();
    check({p, "_start_early"}, 32'(bus_if.upd_start), 0);
    tick();
    check({p, "_start"}, 32'(bus_if.upd_start), 1);
  endtask

  task automatic done_pulse();
    bus_if.upd_done = 1'b1;
    tick();
    bus_if.upd_done = 1'b0;
  endtask

  initial begin
    int starts;
    rst_n = 1'b0;
    h_coord = 11'd3;
    v_coord = '0;
    accel_data_x = '0;
    accel_data_y = '0;
    button_c_d = 1'b0;
    bus_if.upd_done = 1'b0;
    bus_if.clr_err = 1'b0;

    // Reset state
    repeat (3) tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    starts = 0;
    repeat (4) begin
      tick();
      if (bus_if.upd_start === 1'b1) starts++;
    end
    check("no_start_without_frame_end", 32'(starts), 0);

    // Nominal
    accel_data_x = 8'h12;
    accel_data_y = 8'hF0;
    run_start("nom");
    tick();
    check("nom_start_one_cycle", 32'(bus_if.upd_start), 0);
    accel_data_x = 8'h55;
    accel_data_y = 8'hAA;
    repeat (4) tick();
    check("nom_ax_before", 32'(bus_if.accel_x_end_of_frame), 0);
    check("nom_cnt_before", 32'(bus_if.frame_cnt), 0);
    done_pulse();
    check("nom_ax", 32'(bus_if.accel_x_end_of_frame), 32'h12);
    check("nom_ay", 32'(bus_if.accel_y_end_of_frame), 32'hF0);
    check("nom_cnt", 32'(bus_if.frame_cnt), 1);
    tick();
    tick();

    // upd_done outside WAIT is ignored
    done_pulse();
    tick();
    check("idle_done_cnt", 32'(bus_if.frame_cnt), 1);
    check("idle_done_ax", 32'(bus_if.accel_x_end_of_frame), 32'h12);

    // Timeout
    run_start("tmo");
    repeat (16) tick();
    check("tmo_not_yet_err", 32'(bus_if.timeout_err), 0);
    check("tmo_not_yet_cnt", 32'(bus_if.frame_cnt), 1);
    tick();
    check("tmo_err", 32'(bus_if.timeout_err), 1);
    check("tmo_cnt", 32'(bus_if.frame_cnt), 2);
    check("tmo_ax", 32'(bus_if.accel_x_end_of_frame), 32'h55);
    bus_if.clr_err = 1'b1;
    tick();
    bus_if.clr_err = 1'b0;
    check("tmo_clr", 32'(bus_if.timeout_err), 0);
    tick();

    // Done on the expiry cycle
    run_start("col");
    repeat (16) tick();
    done_pulse();
    check("col_terr", 32'(bus_if.timeout_err), 0);
    check("col_cnt", 32'(bus_if.frame_cnt), 3);
    tick();

    // Overrun, with clr_err coinciding with the set event
    accel_data_x = 8'h21;
    accel_data_y = 8'h43;
    run_start("ovr");
    tick();
    tick();
    frame_pulse();
    bus_if.clr_err = 1'b1;
    tick();
    bus_if.clr_err = 1'b0;
    check("ovr_set_wins", 32'(bus_if.overrun_err), 1);
    check("ovr_no_restart", 32'(bus_if.upd_start), 0);
    bus_if.clr_err = 1'b1;
    tick();
    bus_if.clr_err = 1'b0;
    check("ovr_clr", 32'(bus_if.overrun_err), 0);
    done_pulse();
    check("ovr_cnt", 32'(bus_if.frame_cnt), 4);
    check("ovr_ax", 32'(bus_if.accel_x_end_of_frame), 32'h21);
    starts = 0;
    repeat (8) begin
      tick();
      if (bus_if.upd_start === 1'b1) starts++;
    end
    check("ovr_no_extra_start", 32'(starts), 0);
    check("ovr_cnt_stable", 32'(bus_if.frame_cnt), 4);

    // Regime: three presses wrap to 0
    run_start("rg3");
    button_c_d = 1'b1;
    tick();
    tick();
    tick();
    button_c_d = 1'b0;
    check("rg3_before", 32'(bus_if.regime_status), 0);
    done_pulse();
    check("rg3_commit", 32'(bus_if.regime_status), 0);
    check("rg3_cnt", 32'(bus_if.frame_cnt), 5);
    tick();

    // Regime: two presses (one in IDLE, one in WAIT) -> 2
    button_c_d = 1'b1;
    tick();
    button_c_d = 1'b0;
    run_start("rg2");
    button_c_d = 1'b1;
    tick();
    button_c_d = 1'b0;
    check("rg2_before", 32'(bus_if.regime_status), 0);
    done_pulse();
    check("rg2_commit", 32'(bus_if.regime_status), 2);
    check("rg2_cnt", 32'(bus_if.frame_cnt), 6);
    tick();

    // Wrap 16'hFFFF -> 0 without reset
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    tick();
    release dut.frame_cnt_q;
    tick();
    check("wrap_preload", 32'(bus_if.frame_cnt), 32'hFFFF);
    accel_data_x = 8'h3C;
    accel_data_y = 8'hC3;
    run_start("wrap");
    tick();
    done_pulse();
    check("wrap_cnt", 32'(bus_if.frame_cnt), 0);
    check("wrap_ax", 32'(bus_if.accel_x_end_of_frame), 32'h3C);
    check("wrap_ay", 32'(bus_if.accel_y_end_of_frame), 32'hC3);
    check("wrap_reg_held", 32'(bus_if.regime_status), 2);
    tick();

    // Reset mid-WAIT with frame_cnt preloaded to 16'hFFFF
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    tick();
    release dut.frame_cnt_q;
    tick();
    run_start("rmw");
    tick();
    frame_pulse();
    tick();
    check("rmw_ovr_pre", 32'(bus_if.overrun_err), 1);
    check("rmw_cnt_pre", 32'(bus_if.frame_cnt), 32'hFFFF);
    rst_n = 1'b0;
    #1;
    check_all_zero("rmw_async");
    tick();
    tick();
    rst_n = 1'b1;
    starts = 0;
    repeat (3) begin
      tick();
      if (bus_if.upd_start === 1'b1) starts++;
    end
    check("rmw_no_start", 32'(starts), 0);
    accel_data_x = 8'h77;
    accel_data_y = 8'h88;
    run_start("post");
    tick();
    tick();
    done_pulse();
    check("post_cnt", 32'(bus_if.frame_cnt), 1);
    check("post_ax", 32'(bus_if.accel_x_end_of_frame), 32'h77);
    check("post_ay", 32'(bus_if.accel_y_end_of_frame), 32'h88);
    check("post_reg", 32'(bus_if.regime_status), 0);
    check("post_terr", 32'(bus_if.timeout_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
